alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 16-bit combinational ALU between two requesters, for example the instruction datapath and an address/auxiliary unit. Each requester sends an operation (two operands plus a 3-bit mode) over a valid/ready channel. The block registers the operands and drives the ALU from those registers. It captures the ALU result and flags, then returns them on a per-requester valid/ready response channel. Only one operation is in flight at a time.

---
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Operands are registered and held for the ALU. Results are captured and
// returned on a per-requester response channel. Only one operation is in
// flight at a time.
//
// state | meaning
// IDLE  | waiting for a request; ready goes to the selected winner
// EXEC  | ALU evaluates the registered operands; result captured on the edge
// RESP  | response valid to grant_id; held until the requester takes it
module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter int MODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [MODE_W-1:0] req0_mode,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [DATA_W-1:0] rsp0_flags,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [MODE_W-1:0] req1_mode,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [DATA_W-1:0] rsp1_flags,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [MODE_W-1:0] alu_mode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] alu_flags,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   prio;
  logic   grant_id;
  logic   win_valid;
  logic   win_id;
  logic   rsp_done;

  // Winner selection: a lone requester wins; on contention prio decides.
  always_comb begin
    win_valid = req0_valid | req1_valid;
    win_id    = 1'b0;
    if (req0_valid && req1_valid) win_id = prio;
    else if (req1_valid)          win_id = 1'b1;
  end

  assign req0_ready = (state == IDLE) && win_valid && !win_id;
  assign req1_ready = (state == IDLE) && win_valid &&  win_id;

  // Response valid follows registered state only, so reset drops it at once.
  assign rsp0_valid = (state == RESP) && !grant_id;
  assign rsp1_valid = (state == RESP) &&  grant_id;
  assign rsp_done   = grant_id ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
  assign busy       = (state != IDLE);

  // Sequencer: accept, execute for one cycle, then hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      grant_id   <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_mode   <= '0;
      rsp0_data  <= '0;
      rsp0_flags <= '0;
      rsp1_data  <= '0;
      rsp1_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant_id <= win_id;
            state    <= EXEC;
            if (win_id) begin
              alu_in1  <= req1_a;
              alu_in2  <= req1_b;
              alu_mode <= req1_mode;
            end else begin
              alu_in1  <= req0_a;
              alu_in2  <= req0_b;
              alu_mode <= req0_mode;
            end
          end
        end
        EXEC: begin
          if (grant_id) begin
            rsp1_data  <= alu_out;
            rsp1_flags <= alu_flags;
          end else begin
            rsp0_data  <= alu_out;
            rsp0_flags <= alu_flags;
          end
          state <= RESP;
        end
        RESP: begin
          // Fairness is updated only when the response actually completes.
          if (rsp_done) begin
            prio  <= ~grant_id;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int DATA_W = 16;
  localparam int MODE_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [DATA_W-1:0] req0_a, req0_b, rsp0_data, rsp0_flags;
  logic [MODE_W-1:0] req0_mode;
  logic              req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] req1_a, req1_b, rsp1_data, rsp1_flags;
  logic [MODE_W-1:0] req1_mode;
  logic [DATA_W-1:0] alu_in1, alu_in2, alu_out, alu_flags;
  logic [MODE_W-1:0] alu_mode;
  logic              busy;

  int total = 0;
  int fails = 0;

  alu_arbiter #(.DATA_W(DATA_W), .MODE_W(MODE_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_mode(req0_mode), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_flags(rsp0_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_mode(req1_mode), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_flags(rsp1_flags),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_mode(alu_mode),
    .alu_out(alu_out), .alu_flags(alu_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stand-in: flags = {carry/borrow, negative, zero} in bits 2..0.
  logic [DATA_W:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (alu_mode)
      3'd0: alu_wide = {1'b0, alu_in1} + {1'b0, alu_in2};
      3'd1: alu_wide = {1'b0, alu_in1} - {1'b0, alu_in2};
      3'd2: alu_wide = {1'b0, alu_in1 >> alu_in2[3:0]};
      3'd3: alu_wide = {1'b0, alu_in1 << alu_in2[3:0]};
      3'd4: alu_wide = {1'b0, alu_in1 & alu_in2};
      3'd5: alu_wide = {1'b0, alu_in1 | alu_in2};
      3'd6: alu_wide = {1'b0, ~alu_in1};
      default: alu_wide = {1'b0, alu_in1 ^ alu_in2};
    endcase
    alu_out   = alu_wide[DATA_W-1:0];
    alu_flags = {13'b0, alu_wide[DATA_W], alu_wide[DATA_W-1], (alu_wide[DATA_W-1:0] == '0)};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, n1, id;
    logic [DATA_W-1:0] exp_d;

    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_mode = 0; rsp0_ready = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_mode = 0; rsp1_ready = 0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_alu_mode", alu_mode, 0);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_data", rsp0_data, 0);
    chk("rst_req0_ready", req0_ready, 0);
    rst = 1'b0;

    // 1: ADD 3+4 from requester 0
    req0_valid = 1; req0_a = 16'h0003; req0_b = 16'h0004; req0_mode = 3'd0;
    #1;
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    step();
    req0_valid = 0;
    chk("t1_ready_drop", req0_ready, 0);
    chk("t1_busy", busy, 1);
    chk("t1_alu_in1", alu_in1, 16'h0003);
    chk("t1_alu_in2", alu_in2, 16'h0004);
    chk("t1_rsp0_valid_exec", rsp0_valid, 0);
    step();
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp0_data", rsp0_data, 16'h0007);
    chk("t1_rsp0_flags", rsp0_flags, 16'h0000);
    chk("t1_rsp1_valid", rsp1_valid, 0);
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    chk("t1_rsp0_valid_done", rsp0_valid, 0);
    chk("t1_busy_done", busy, 0);

    // 2: SHIFTL 1<<4 from requester 1, then back-to-back accept of requester 0
    req1_valid = 1; req1_a = 16'h0001; req1_b = 16'h0004; req1_mode = 3'd3; rsp1_ready = 1;
    #1;
    chk("t2_req1_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    req0_valid = 1; req0_a = 16'h0100; req0_b = 16'h0001; req0_mode = 3'd0;
    step();
    chk("t2_rsp1_valid", rsp1_valid, 1);
    chk("t2_rsp1_data", rsp1_data, 16'h0010);
    chk("t2_req0_blocked", req0_ready, 0);
    step();
    chk("t2_rsp1_valid_done", rsp1_valid, 0);
    chk("t2_req0_ready_3rd", req0_ready, 1);

    // 3: both requesters continuously valid; prio is 0 so order is 0,1,0,1,...
    rsp0_ready = 1; rsp1_ready = 1;
    n0 = 0; n1 = 0;
    req0_a = 16'h0001; req0_b = 16'h0100; req0_mode = 3'd0;
    req1_a = 16'h00F0; req1_b = 16'h0000; req1_mode = 3'd7;
    req1_valid = 1;
    #1;
    for (int op = 0; op < 8; op++) begin
      id = op % 2;
      chk($sformatf("t3_op%0d_ready0", op), req0_ready, (id == 0) ? 1 : 0);
      chk($sformatf("t3_op%0d_ready1", op), req1_ready, (id == 1) ? 1 : 0);
      step();
      if (id == 0) begin
        exp_d = 16'h0101 + 16'(n0);
        n0++;
        if (n0 == 4) req0_valid = 0;
        else req0_a = 16'h0001 + 16'(n0);
      end else begin
        exp_d = 16'h00F0 ^ 16'(n1);
        n1++;
        if (n1 == 4) req1_valid = 0;
        else req1_b = 16'(n1);
      end
      step();
      if (id == 0) chk($sformatf("t3_op%0d_data0", op), rsp0_data, exp_d);
      else chk($sformatf("t3_op%0d_data1", op), rsp1_data, exp_d);
      chk($sformatf("t3_op%0d_valid", op), {30'b0, rsp1_valid, rsp0_valid}, (id == 0) ? 1 : 2);
      step();
    end
    chk("t3_idle", busy, 0);

    // 4: response back-pressure on requester 0 while requester 1 waits
    rsp0_ready = 0; rsp1_ready = 0;
    req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h0F0F; req0_mode = 3'd4;
    step();
    req0_valid = 0;
    req1_valid = 1; req1_a = 16'h0007; req1_b = 16'h0001; req1_mode = 3'd1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_hold%0d_valid", i), rsp0_valid, 1);
      chk($sformatf("t4_hold%0d_data", i), rsp0_data, 16'h0204);
      chk($sformatf("t4_hold%0d_flags", i), rsp0_flags, 16'h0000);
      chk($sformatf("t4_hold%0d_req1_ready", i), req1_ready, 0);
      step();
    end
    rsp0_ready = 1;
    #1;
    chk("t4_req1_ready_resp", req1_ready, 0);
    step();
    rsp0_ready = 0;
    chk("t4_req1_ready_idle", req1_ready, 1);
    step();
    req1_valid = 0; rsp1_ready = 1;
    step();
    chk("t4_rsp1_data", rsp1_data, 16'h0006);
    step();
    rsp1_ready = 0;

    // 5: complete one req0 op so prio=1, then reset during EXEC
    rsp0_ready = 1;
    req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0001; req0_mode = 3'd0;
    step();
    req0_valid = 0;
    step(); step();
    req0_valid = 1; req0_a = 16'h0009; req0_b = 16'h0009; req0_mode = 3'd5;
    step();
    req0_valid = 0;
    chk("t5_alu_mode_pre", alu_mode, 5);
    chk("t5_busy_pre", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_busy_rst", busy, 0);
    chk("t5_alu_mode_rst", alu_mode, 0);
    chk("t5_rsp0_valid_rst", rsp0_valid, 0);
    step();
    rst = 1'b0;
    step(); step();
    chk("t5_no_rsp0", rsp0_valid, 0);
    chk("t5_no_rsp1", rsp1_valid, 0);
    req0_valid = 1; req0_a = 16'h0005; req0_b = 16'h0005; req0_mode = 3'd1;
    req1_valid = 1; req1_a = 16'h0000; req1_b = 16'h0000; req1_mode = 3'd0;
    #1;
    chk("t5_prio0_ready0", req0_ready, 1);
    chk("t5_prio0_ready1", req1_ready, 0);

    // 6: SUBST 5-5 -> zero result, zero flag only
    step();
    req0_valid = 0; req1_valid = 0;
    step();
    chk("t6_rsp0_data", rsp0_data, 16'h0000);
    chk("t6_rsp0_flags", rsp0_flags, 16'h0001);
    chk("t6_rsp0_valid", rsp0_valid, 1);
    step();
    chk("t6_alu_in1", alu_in1, 16'h0005);
    chk("t6_alu_in2", alu_in2, 16'h0005);
    chk("t6_rsp0_valid_done", rsp0_valid, 0);
    chk("t6_busy", busy, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
